// File: rtl/saturate_narrow_if.sv
// saturate_narrow_if: input/output handshake bundle for the saturating narrower
interface saturate_narrow_if #(parameter int M = 16, parameter int N = 8);
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] in_data;
  logic         in_signed;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_sat;
  modport master(output in_valid, in_data, in_signed, out_ready,
                 input in_ready, out_valid, out_data, out_sat);
  modport slave(input in_valid, in_data, in_signed, out_ready,
                output in_ready, out_valid, out_data, out_sat);
endinterface

// File: rtl/saturate_narrow.sv
// saturate_narrow: clamps M-bit signed results to N-bit lanes through a 2-entry FIFO
module saturate_narrow #(
  parameter int M     = 16,
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  saturate_narrow_if.slave bus,
  output logic [CNT_W-1:0] sat_count,
  output logic             sat_sticky
);
  logic [N-1:0]     mem_q [2];
  logic             sat_q [2];
  logic             rd_q, wr_q, in_ready_q, sticky_q, sticky_d;
  logic [1:0]       occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [N-1:0]     cl_data;
  logic             cl_sat, s_ovf, u_neg, u_big, acc, pop;
  always_comb begin
    // signed fits iff bits [M-1:N-1] are all copies of the sign bit
    s_ovf    = !((&bus.in_data[M-1:N-1]) || !(|bus.in_data[M-1:N-1]));
    u_neg    = bus.in_data[M-1];
    u_big    = !u_neg && (|bus.in_data[M-1:N]);
    cl_sat   = bus.in_signed ? s_ovf : (u_neg || u_big);
    cl_data  = bus.in_signed
             ? (s_ovf ? {bus.in_data[M-1], {(N-1){!bus.in_data[M-1]}}} : bus.in_data[N-1:0])
             : (u_neg ? '0 : (u_big ? '1 : bus.in_data[N-1:0]));
    acc      = bus.in_valid && in_ready_q;
    pop      = (occ_q != 2'd0) && bus.out_ready;
    occ_d    = occ_q + {1'b0, acc} - {1'b0, pop};
    cnt_base = clear ? '0 : cnt_q;
    cnt_d    = (acc && cl_sat && !(&cnt_base)) ? cnt_base + 1'b1 : cnt_base;
    sticky_d = (!clear && sticky_q) || (acc && cl_sat);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      sat_q      <= '{default: 1'b0};
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      occ_q      <= 2'd0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
    end else begin
      if (acc) begin
        mem_q[wr_q] <= cl_data;
        sat_q[wr_q] <= cl_sat;
        wr_q        <= !wr_q;
      end
      if (pop) rd_q <= !rd_q;
      occ_q      <= occ_d;
      in_ready_q <= occ_d != 2'd2;
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
    end
  end
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = occ_q != 2'd0;
  assign bus.out_data  = mem_q[rd_q];
  assign bus.out_sat   = sat_q[rd_q];
  assign sat_count     = cnt_q;
  assign sat_sticky    = sticky_q;
endmodule

// File: tb/tb_saturate_narrow.sv
// tb_saturate_narrow: randomized and directed checks against a queue-based reference model
module tb_saturate_narrow;
  localparam int M = 16;
  localparam int N = 8;
  localparam int SMAX = (1 << (N - 1)) - 1;
  localparam int SMIN = -(1 << (N - 1));
  localparam int UMAX = (1 << N) - 1;
  typedef struct packed {logic [N-1:0] d; logic s;} ent_t;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0;
  logic [15:0] cnt;
  logic [1:0]  cnt2;
  logic        sticky, sticky2;
  int          total = 0, bad = 0, count = 0;
  bit          m_sticky = 0, m_rdy = 1;
  ent_t        q[$];
  logic [N-1:0] gotq[$];
  always #5 clk = ~clk;
  saturate_narrow_if #(.M(M), .N(N)) bus ();
  saturate_narrow_if #(.M(M), .N(N)) bus2 ();
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_data   = bus.in_data;
  assign bus2.in_signed = bus.in_signed;
  assign bus2.out_ready = bus.out_ready;
  saturate_narrow #(.M(M), .N(N), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus), .sat_count(cnt), .sat_sticky(sticky));
  saturate_narrow #(.M(M), .N(N), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus2), .sat_count(cnt2), .sat_sticky(sticky2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ent_t ref_clamp(input logic [M-1:0] x, input logic sgn);
    int v, c;
    ent_t e;
    v = int'($signed(x));
    c = sgn ? (v > SMAX ? SMAX : (v < SMIN ? SMIN : v))
            : (v > UMAX ? UMAX : (v < 0 ? 0 : v));
    e.d = N'(c);
    e.s = (c != v);
    return e;
  endfunction

  task automatic cyc();
    ent_t e;
    bit acc, pop;
    acc = bus.in_valid && m_rdy;
    pop = bus.out_ready && q.size() != 0;
    if (bus.out_valid && bus.out_ready) gotq.push_back(bus.out_data);
    if (rst) begin
      q.delete();
      count = 0;
      m_sticky = 0;
    end else begin
      if (clear) begin
        count = 0;
        m_sticky = 0;
      end
      if (pop) e = q.pop_front();
      if (acc) begin
        e = ref_clamp(bus.in_data, bus.in_signed);
        q.push_back(e);
        if (e.s) begin
          count++;
          m_sticky = 1;
        end
      end
    end
    m_rdy = q.size() < 2;
    @(posedge clk);
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_data", 32'(bus.out_data), 32'(q[0].d));
      chk("out_sat", 32'(bus.out_sat), 32'(q[0].s));
    end else if (rst) begin
      chk("rst_data", 32'(bus.out_data), 32'd0);
      chk("rst_sat", 32'(bus.out_sat), 32'd0);
    end
    chk("sat_count", 32'(cnt), 32'(count > 65535 ? 65535 : count));
    chk("sat_count2", 32'(cnt2), 32'(count > 3 ? 3 : count));
    chk("sticky", 32'(sticky), 32'(m_sticky));
    chk("sticky2", 32'(sticky2), 32'(m_sticky));
  endtask

  logic [15:0] vd [9] = '{16'h007F, 16'h0080, 16'hFF80, 16'hFF7F, 16'h8000,
                          16'h00FF, 16'h0100, 16'hFFFF, 16'h0000};
  logic        vs [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
  logic [7:0]  ed [9] = '{8'h7F, 8'h7F, 8'h80, 8'h80, 8'h80, 8'hFF, 8'hFF, 8'h00, 8'h00};
  logic        es [9] = '{0, 1, 0, 1, 1, 0, 1, 1, 0};

  initial begin
    logic [31:0] r;
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.in_signed = 0;
    bus.out_ready = 1;
    cyc();
    cyc();
    rst = 0;
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1;
      bus.in_data = vd[i];
      bus.in_signed = vs[i];
      cyc();
      chk("vec_data", 32'(bus.out_data), 32'(ed[i]));
      chk("vec_sat", 32'(bus.out_sat), 32'(es[i]));
      if (i == 4) chk("signed_cnt", 32'(cnt), 32'd3);
    end
    bus.in_valid = 0;
    cyc();
    chk("vec_sticky", 32'(sticky), 32'd1);
    // backpressure: third word must wait until a slot frees
    gotq.delete();
    bus.out_ready = 0;
    bus.in_signed = 1;
    bus.in_valid = 1;
    bus.in_data = 16'h0011;
    cyc();
    bus.in_data = 16'h0022;
    cyc();
    chk("bp_full", 32'(bus.in_ready), 32'd0);
    bus.in_data = 16'h0033;
    cyc();
    cyc();
    chk("bp_head", 32'(bus.out_data), 32'h11);
    bus.out_ready = 1;
    cyc();
    cyc();
    bus.in_valid = 0;
    cyc();
    cyc();
    chk("bp_n", 32'(gotq.size()), 32'd3);
    if (gotq.size() == 3) begin
      chk("bp_0", 32'(gotq[0]), 32'h11);
      chk("bp_1", 32'(gotq[1]), 32'h22);
      chk("bp_2", 32'(gotq[2]), 32'h33);
    end
    // full-rate streaming
    gotq.delete();
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1;
      bus.in_data = 16'(i * 37 - 200);
      bus.in_signed = i[0];
      cyc();
      chk("stream_rdy", 32'(bus.in_ready), 32'd1);
      chk("stream_vld", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 0;
    cyc();
    chk("stream_n", 32'(gotq.size()), 32'd16);
    // 2-bit counter saturation
    clear = 1;
    cyc();
    clear = 0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1;
      bus.in_data = 16'h0100;
      bus.in_signed = 0;
      cyc();
      chk("cnt2_seq", 32'(cnt2), 32'(i < 3 ? i + 1 : 3));
    end
    clear = 1;
    cyc();
    chk("clr_evt_cnt", 32'(cnt), 32'd1);
    chk("clr_evt_sticky", 32'(sticky), 32'd1);
    clear = 0;
    // random traffic biased toward clamp boundaries
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      bus.in_valid = r[0] | r[1];
      bus.out_ready = r[2] | r[3];
      bus.in_signed = r[4];
      clear = (r[7:5] == 3'd0) && r[8];
      bus.in_data = r[9] ? 16'($urandom) : {{6{r[19]}}, r[19:10]};
      cyc();
    end
    clear = 0;
    // reset with a full buffer drops both words
    bus.out_ready = 0;
    bus.in_valid = 1;
    bus.in_signed = 0;
    bus.in_data = 16'h0300;
    cyc();
    cyc();
    chk("pre_rst_full", 32'(bus.in_ready), 32'd0);
    rst = 1;
    cyc();
    rst = 0;
    bus.in_valid = 0;
    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_sticky", 32'(sticky), 32'd0);
    bus.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stale", 32'(bus.out_valid), 32'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
